// File: rtl/seq_compare_n_if.sv
// Start/done compare bus between the ALU controller (master) and seq_compare_n (slave).
interface seq_compare_n_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic [2:0]   mode;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] C;
  logic         lt;
  logic         eq;

  modport master (output start, mode, A, B, input busy, done, C, lt, eq);
  modport slave  (input start, mode, A, B, output busy, done, C, lt, eq);
endinterface

// File: rtl/seq_compare_n.sv
// Iterative signed/unsigned compare with SLT/MIN/MAX/EQ results.
// Resolves MSB-first, W bits per cycle, fixed latency of N/W cycles.
module seq_compare_n #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_compare_n_if.slave  bus
);
  localparam int unsigned DIGITS = N / W;
  localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);
  localparam logic [N-1:0] MSB_MASK = {1'b1, {(N-1){1'b0}}};

  localparam logic [2:0] M_SLT  = 3'b000;
  localparam logic [2:0] M_SLTU = 3'b001;
  localparam logic [2:0] M_MIN  = 3'b010;
  localparam logic [2:0] M_MAX  = 3'b011;
  localparam logic [2:0] M_MINU = 3'b100;
  localparam logic [2:0] M_MAXU = 3'b101;
  localparam logic [2:0] M_EQ   = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]     r_mode;
  logic [N-1:0]   r_a_org;
  logic [N-1:0]   r_b_org;
  logic [N-1:0]   r_a_sh;
  logic [N-1:0]   r_b_sh;
  logic           r_res;
  logic           r_lt_w;
  logic           r_busy;
  logic           r_done;
  logic [N-1:0]   r_c;
  logic           r_lt;
  logic           r_eq;

  logic           w_accept;
  logic           w_signed;
  logic [N-1:0]   w_flip;
  logic [W-1:0]   w_a_dig;
  logic [W-1:0]   w_b_dig;
  logic           w_diff;
  logic           w_res_nx;
  logic           w_lt_nx;
  logic           w_eq_nx;
  logic [N-1:0]   w_c;

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.C    = r_c;
  assign bus.lt   = r_lt;
  assign bus.eq   = r_eq;

  // Signed modes bias the MSB so a plain unsigned digit compare gives the signed order
  assign w_accept = bus.start && (r_state != S_RUN);
  assign w_signed = (bus.mode == M_SLT) || (bus.mode == M_MIN) || (bus.mode == M_MAX);
  assign w_flip   = w_signed ? MSB_MASK : '0;

  // Current digit step; the first differing digit decides lt
  always_comb begin
    w_a_dig  = r_a_sh[N-1 -: W];
    w_b_dig  = r_b_sh[N-1 -: W];
    w_diff   = (w_a_dig != w_b_dig);
    w_res_nx = r_res | w_diff;
    w_lt_nx  = r_lt_w;
    if (!r_res && w_diff) begin
      w_lt_nx = (w_a_dig < w_b_dig);
    end
    w_eq_nx = ~w_res_nx;
  end

  always_comb begin
    w_c = '0;
    case (r_mode)
      M_SLT, M_SLTU: w_c = {{(N-1){1'b0}}, w_lt_nx};
      M_MIN, M_MINU: w_c = w_lt_nx ? r_a_org : r_b_org;
      M_MAX, M_MAXU: w_c = w_lt_nx ? r_b_org : r_a_org;
      M_EQ:          w_c = {{(N-1){1'b0}}, w_eq_nx};
      default:       w_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mode  <= '0;
      r_a_org <= '0;
      r_b_org <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= 1'b0;
      r_lt_w  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_c     <= '0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_state <= S_RUN;
        r_cnt   <= '0;
        r_mode  <= bus.mode;
        r_a_org <= bus.A;
        r_b_org <= bus.B;
        r_a_sh  <= bus.A ^ w_flip;
        r_b_sh  <= bus.B ^ w_flip;
        r_res   <= 1'b0;
        r_lt_w  <= 1'b0;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_IDLE;
          S_RUN: begin
            r_res  <= w_res_nx;
            r_lt_w <= w_lt_nx;
            r_a_sh <= r_a_sh << W;
            r_b_sh <= r_b_sh << W;
            if (r_cnt == LAST_CNT) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_c     <= w_c;
              r_lt    <= w_lt_nx;
              r_eq    <= w_eq_nx;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
